keypad_bcd_debounced_encoder: RTL and testbench

//   Parametrised keypad front end: one-hot key lines -> binary/BCD key code. Adds input synchronisation,

---
 rtl/keypad_bcd_debounced_encoder.sv | 139 +++++++++++++
 tb/tb_keypad_bcd_debounced_encoder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_bcd_debounced_encoder.sv
// One-hot keypad lines -> key index, with 2-flop synchroniser, press/release debounce,
// single-cycle accept pulse and multi-key error flag. All outputs registered.
module keypad_bcd_debounced_encoder #(
  parameter int N_KEYS     = 10,
  parameter int CODE_W     = 4,
  parameter int DEB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] dec,
  output logic [CODE_W-1:0] BCD,
  output logic              tecla_acionada,
  output logic              tecla_valida,
  output logic              erro_multi
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);

  typedef enum logic [2:0] {IDLE, DB_PRESS, PRESSED, DB_RELEASE, ERROR} state_t;

  state_t              state, state_n;
  logic [N_KEYS-1:0]   s1, s, cand, cand_n;
  logic [CNT_W-1:0]    cnt, cnt_n, cnt_inc;
  logic [CODE_W-1:0]   bcd_n;
  logic                acion_n, valid_n, err_n, s_zero;

  function automatic logic is_one(input logic [N_KEYS-1:0] v);
    return (v != '0) && ((v & (v - N_KEYS'(1))) == '0);
  endfunction

  function automatic logic [CODE_W-1:0] key_index(input logic [N_KEYS-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_KEYS; i++)
      if (v[i]) idx = CODE_W'(i);
    return idx;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s  <= '0;
    end else begin
      s1 <= dec;
      s  <= s1;
    end
  end

  assign s_zero  = (s == '0);
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cand           <= '0;
      cnt            <= '0;
      BCD            <= '0;
      tecla_acionada <= 1'b0;
      tecla_valida   <= 1'b0;
      erro_multi     <= 1'b0;
    end else begin
      state          <= state_n;
      cand           <= cand_n;
      cnt            <= cnt_n;
      BCD            <= bcd_n;
      tecla_acionada <= acion_n;
      tecla_valida   <= valid_n;
      erro_multi     <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    bcd_n   = BCD;
    acion_n = tecla_acionada;
    valid_n = 1'b0;
    err_n   = erro_multi;
    case (state)
      IDLE: if (!s_zero) begin
        cand_n  = s;
        cnt_n   = CNT_W'(1);
        state_n = DB_PRESS;
      end
      DB_PRESS: begin
        if (s_zero) state_n = IDLE;
        else if (s != cand) begin
          cand_n = s;
          cnt_n  = CNT_W'(1);
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            if (is_one(cand)) begin
              bcd_n   = key_index(cand);
              valid_n = 1'b1;
              acion_n = 1'b1;
              state_n = PRESSED;
            end else begin
              // start release timing from zero so a prompt release still waits the full window
              err_n   = 1'b1;
              cnt_n   = '0;
              state_n = ERROR;
            end
          end
        end
      end
      PRESSED: if (s_zero) begin
        cnt_n   = CNT_W'(1);
        state_n = DB_RELEASE;
      end
      DB_RELEASE: begin
        if (!s_zero) begin
          cnt_n   = '0;
          state_n = PRESSED;
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            acion_n = 1'b0;
            state_n = IDLE;
          end
        end
      end
      ERROR: begin
        if (!s_zero) cnt_n = '0;
        else begin
          cnt_n = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            err_n   = 1'b0;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_keypad_bcd_debounced_encoder.sv
// Bench for keypad_bcd_debounced_encoder: scenario tasks with inline checks plus a pulse
// scoreboard (expected codes queued at stimulus time, popped on each tecla_valida).
module tb_keypad_bcd_debounced_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  dec;
  logic [3:0]  bcd;
  logic        acion, valid, err;
  logic [15:0] dec16;
  logic [3:0]  bcd16;
  logic        acion16, valid16, err16;

  int checks = 0;
  int failures = 0;
  int q[$];
  int q16[$];
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  keypad_bcd_debounced_encoder #(.N_KEYS(10), .CODE_W(4), .DEB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .dec(dec), .BCD(bcd),
    .tecla_acionada(acion), .tecla_valida(valid), .erro_multi(err));

  keypad_bcd_debounced_encoder #(.N_KEYS(16), .CODE_W(4), .DEB_CYCLES(4)) dut16 (
    .clk(clk), .rst(rst), .dec(dec16), .BCD(bcd16),
    .tecla_acionada(acion16), .tecla_valida(valid16), .erro_multi(err16));

  // scoreboard monitors: every pulse must match a queued expected code
  always @(negedge clk) begin
    if (valid) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_pulse: got pulse with BCD=%0d, expected no pulse", bcd);
      end else begin
        int e;
        e = q.pop_front();
        if (bcd !== 4'(e)) begin
          failures++;
          $display("FAIL sb_bcd: got %0d expected %0d", bcd, e);
        end
      end
      checks++;
      if (prev_valid || err) begin
        failures++;
        $display("FAIL sb_pulse_rule: prev_valid=%0b erro_multi=%0b, expected both 0", prev_valid, err);
      end
    end
    prev_valid = valid;
  end

  always @(negedge clk) begin
    if (valid16) begin
      checks++;
      if (q16.size() == 0) begin
        failures++;
        $display("FAIL sb16_unexpected_pulse: got BCD=%0d, expected no pulse", bcd16);
      end else begin
        int e;
        e = q16.pop_front();
        if (bcd16 !== 4'(e)) begin
          failures++;
          $display("FAIL sb16_bcd: got %0d expected %0d", bcd16, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // press a single key and check the pulse lands exactly at the 6th edge
  task automatic press_accept(input logic [9:0] v, input int code, input string name);
    dec = v;
    q.push_back(code);
    repeat (5) tick();
    checks++;
    if (valid !== 1'b0 || acion !== 1'b0) begin
      failures++;
      $display("FAIL %s_early: valid=%0b acion=%0b expected 0 0", name, valid, acion);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || acion !== 1'b1 || bcd !== 4'(code)) begin
      failures++;
      $display("FAIL %s_accept: valid=%0b acion=%0b bcd=%0d expected 1 1 %0d", name, valid, acion, bcd, code);
    end
  endtask

  task automatic release_all();
    dec = '0;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dec = '0;
    dec16 = '0;
    #1;
    checks++;
    if (bcd !== 4'd0 || acion !== 1'b0 || valid !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: bcd=%0d acion=%0b valid=%0b err=%0b expected all 0", bcd, acion, valid, err);
    end
    tick();
    tick();
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_press_release();
    press_accept(10'h008, 3, "press3");
    tick();
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL press3_single: valid=%0b expected 0", valid);
    end
    tick();
    dec = '0;
    repeat (5) tick();
    checks++;
    if (acion !== 1'b1) begin
      failures++;
      $display("FAIL release3_early: acion=%0b expected 1", acion);
    end
    tick();
    checks++;
    if (acion !== 1'b0 || bcd !== 4'd3) begin
      failures++;
      $display("FAIL release3: acion=%0b bcd=%0d expected 0 3", acion, bcd);
    end
    repeat (3) tick();
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 8; i++) begin
      dec = (i % 2 == 0) ? 10'h008 : 10'h000;
      tick();
      checks++;
      if (valid !== 1'b0 || acion !== 1'b0) begin
        failures++;
        $display("FAIL bounce_%0d: valid=%0b acion=%0b expected 0 0", i, valid, acion);
      end
    end
    press_accept(10'h008, 3, "bounce_hold");
    release_all();
  endtask

  task automatic test_multi();
    dec = 10'h021;
    repeat (5) tick();
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL multi_early: err=%0b expected 0", err);
    end
    tick();
    checks++;
    if (err !== 1'b1 || valid !== 1'b0 || bcd !== 4'd3 || acion !== 1'b0) begin
      failures++;
      $display("FAIL multi_set: err=%0b valid=%0b bcd=%0d acion=%0b expected 1 0 3 0", err, valid, bcd, acion);
    end
    repeat (3) tick();
    dec = '0;
    repeat (5) tick();
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL multi_hold: err=%0b expected 1", err);
    end
    tick();
    checks++;
    if (err !== 1'b0 || bcd !== 4'd3) begin
      failures++;
      $display("FAIL multi_clear: err=%0b bcd=%0d expected 0 3", err, bcd);
    end
    press_accept(10'h200, 9, "after_err9");
    release_all();
  endtask

  task automatic test_no_rollover();
    press_accept(10'h020, 5, "key5");
    dec = 10'h0A0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (valid !== 1'b0 || bcd !== 4'd5 || err !== 1'b0) begin
        failures++;
        $display("FAIL rollover_%0d: valid=%0b bcd=%0d err=%0b expected 0 5 0", i, valid, bcd, err);
      end
    end
    release_all();
    press_accept(10'h080, 7, "key7");
    release_all();
    press_accept(10'h001, 0, "key0");
    release_all();
  endtask

  task automatic test_glitch();
    dec = 10'h200;
    repeat (3) tick();
    dec = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (valid !== 1'b0 || acion !== 1'b0 || bcd !== 4'd0) begin
        failures++;
        $display("FAIL glitch_%0d: valid=%0b acion=%0b bcd=%0d expected 0 0 0", i, valid, acion, bcd);
      end
    end
    press_accept(10'h004, 2, "key2");
    repeat (2) tick();
    dec = '0;
    repeat (2) tick();
    dec = 10'h004;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (acion !== 1'b1 || valid !== 1'b0) begin
        failures++;
        $display("FAIL rel_bounce_%0d: acion=%0b valid=%0b expected 1 0", i, acion, valid);
      end
    end
    release_all();
  endtask

  task automatic test_reset_mid();
    press_accept(10'h010, 4, "key4");
    tick();
    rst = 1'b1;
    #2;
    checks++;
    if (bcd !== 4'd0 || acion !== 1'b0 || valid !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: bcd=%0d acion=%0b valid=%0b err=%0b expected all 0", bcd, acion, valid, err);
    end
    tick();
    tick();
    rst = 1'b0;
    press_accept(10'h010, 4, "repress4");
    release_all();
  endtask

  task automatic test_wide_keys();
    dec16 = 16'h8000;
    q16.push_back(15);
    repeat (5) tick();
    checks++;
    if (valid16 !== 1'b0) begin
      failures++;
      $display("FAIL key15_early: valid=%0b expected 0", valid16);
    end
    tick();
    checks++;
    if (valid16 !== 1'b1 || bcd16 !== 4'hF || acion16 !== 1'b1) begin
      failures++;
      $display("FAIL key15_accept: valid=%0b bcd=%0h acion=%0b expected 1 f 1", valid16, bcd16, acion16);
    end
    dec16 = '0;
    repeat (5) tick();
    checks++;
    if (acion16 !== 1'b1) begin
      failures++;
      $display("FAIL key15_rel_early: acion=%0b expected 1", acion16);
    end
    tick();
    checks++;
    if (acion16 !== 1'b0 || bcd16 !== 4'hF) begin
      failures++;
      $display("FAIL key15_release: acion=%0b bcd=%0h expected 0 f", acion16, bcd16);
    end
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_multi();
    test_no_rollover();
    test_glitch();
    test_reset_mid();
    test_wide_keys();
    checks++;
    if (q.size() != 0 || q16.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: pending=%0d/%0d expected 0/0", q.size(), q16.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
